// File: rtl/bp_me_pkg.sv
// Shared ME types for the UCE memory arbiter slice: requester source identifiers.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_src_icache = 1'b0,
    e_src_dcache = 1'b1
  } bp_uce_arb_src_e;

endpackage

// File: rtl/bp_uce_mem_arbiter_if.sv
// Handshake bundle between two UCE requesters, the cce_mem channel and the arbiter.
interface bp_uce_mem_arbiter_if #(
  parameter int unsigned msg_width_p       = 600,
  parameter int unsigned max_outstanding_p = 8
);
  localparam int unsigned ptr_width_lp = $clog2(max_outstanding_p);

  logic [msg_width_p-1:0]  cmd0_i;
  logic                    cmd0_v_i;
  logic                    cmd0_ready_o;
  logic [msg_width_p-1:0]  cmd1_i;
  logic                    cmd1_v_i;
  logic                    cmd1_ready_o;

  logic [msg_width_p-1:0]  mem_cmd_o;
  logic                    mem_cmd_v_o;
  logic                    mem_cmd_ready_i;
  logic [msg_width_p-1:0]  mem_resp_i;
  logic                    mem_resp_v_i;
  logic                    mem_resp_yumi_o;

  logic [msg_width_p-1:0]  resp0_o;
  logic                    resp0_v_o;
  logic                    resp0_yumi_i;
  logic [msg_width_p-1:0]  resp1_o;
  logic                    resp1_v_o;
  logic                    resp1_yumi_i;

  logic [ptr_width_lp:0]   outstanding_o;
  logic                    error_o;

  // Arbiter side
  modport slave (
    input  cmd0_i, cmd0_v_i, cmd1_i, cmd1_v_i,
    output cmd0_ready_o, cmd1_ready_o,
    output mem_cmd_o, mem_cmd_v_o,
    input  mem_cmd_ready_i,
    input  mem_resp_i, mem_resp_v_i,
    output mem_resp_yumi_o,
    output resp0_o, resp0_v_o, resp1_o, resp1_v_o,
    input  resp0_yumi_i, resp1_yumi_i,
    output outstanding_o, error_o
  );

  // Environment side (requesters plus memory)
  modport master (
    output cmd0_i, cmd0_v_i, cmd1_i, cmd1_v_i,
    input  cmd0_ready_o, cmd1_ready_o,
    input  mem_cmd_o, mem_cmd_v_o,
    output mem_cmd_ready_i,
    output mem_resp_i, mem_resp_v_i,
    input  mem_resp_yumi_o,
    input  resp0_o, resp0_v_o, resp1_o, resp1_v_o,
    output resp0_yumi_i, resp1_yumi_i,
    input  outstanding_o, error_o
  );

endinterface

// File: rtl/bp_uce_mem_arb_order_fifo.sv
// In-order source tracking FIFO: one requester id per in-flight command.
module bp_uce_mem_arb_order_fifo
  import bp_me_pkg::*;
#(
  parameter  int unsigned depth_p      = 8,
  localparam int unsigned ptr_width_lp = $clog2(depth_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  push_i,
  input  bp_uce_arb_src_e       data_i,
  input  logic                  pop_i,
  output bp_uce_arb_src_e       data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ptr_width_lp:0] count_o
);

  bp_uce_arb_src_e       mem_r [depth_p];
  logic [ptr_width_lp:0] wptr_r, rptr_r;
  logic                  do_push_c, do_pop_c;

  assign do_push_c = push_i & ~full_o;
  assign do_pop_c  = pop_i  & ~empty_o;

  // Extra MSB on each pointer separates full from empty at equal indices
  assign empty_o = (wptr_r == rptr_r);
  assign full_o  = (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp]) &&
                   (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0]);
  assign count_o = wptr_r - rptr_r;
  assign data_o  = mem_r[rptr_r[ptr_width_lp-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < int'(depth_p); i++) mem_r[i] <= e_src_icache;
    end else begin
      if (do_push_c) begin
        mem_r[wptr_r[ptr_width_lp-1:0]] <= data_i;
        wptr_r <= wptr_r + (ptr_width_lp+1)'(1);
      end
      if (do_pop_c) rptr_r <= rptr_r + (ptr_width_lp+1)'(1);
    end
  end

endmodule

// File: rtl/bp_uce_mem_arbiter.sv
// Two-UCE to one cce_mem arbiter with registered command stage and in-order response routing.
// Define BP_UCE_MEM_ARB_FIXED_PRIO_EN for fixed priority (icache wins ties) instead of round-robin.
module bp_uce_mem_arbiter
  import bp_me_pkg::*;
#(
  parameter  int unsigned msg_width_p       = 600,
  parameter  int unsigned max_outstanding_p = 8,
  localparam int unsigned ptr_width_lp      = $clog2(max_outstanding_p)
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  bp_uce_mem_arbiter_if.slave bus
);

  logic                   stage_v_r;
  logic [msg_width_p-1:0] stage_data_r;
  logic                   error_r;

  logic                   fifo_full, fifo_empty;
  bp_uce_arb_src_e        fifo_head;
  logic [ptr_width_lp:0]  fifo_count;

  logic                   accept_c, pref_dcache_c;
  logic                   xfer0_c, xfer1_c, push_c, pop_c;
  bp_uce_arb_src_e        push_src_c;

`ifdef BP_UCE_MEM_ARB_FIXED_PRIO_EN
  assign pref_dcache_c = 1'b0;
`else
  bp_uce_arb_src_e last_grant_r;

  assign pref_dcache_c = (last_grant_r == e_src_icache);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   last_grant_r <= e_src_dcache;
    else if (xfer0_c) last_grant_r <= e_src_icache;
    else if (xfer1_c) last_grant_r <= e_src_dcache;
  end
`endif

  // No bypass: a full tracker blocks accept even while a response pops
  assign accept_c = (~stage_v_r | bus.mem_cmd_ready_i) & ~fifo_full;

  // A port's ready looks only at the competitor's valid and the tie preference
  assign bus.cmd0_ready_o = accept_c & (~bus.cmd1_v_i | ~pref_dcache_c);
  assign bus.cmd1_ready_o = accept_c & (~bus.cmd0_v_i |  pref_dcache_c);

  assign xfer0_c    = bus.cmd0_v_i & bus.cmd0_ready_o;
  assign xfer1_c    = bus.cmd1_v_i & bus.cmd1_ready_o;
  assign push_c     = xfer0_c | xfer1_c;
  assign push_src_c = bp_uce_arb_src_e'(xfer1_c);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_v_r    <= 1'b0;
      stage_data_r <= '0;
    end else if (push_c) begin
      stage_v_r    <= 1'b1;
      stage_data_r <= xfer1_c ? bus.cmd1_i : bus.cmd0_i;
    end else if (bus.mem_cmd_ready_i) begin
      stage_v_r    <= 1'b0;
    end
  end

  assign bus.mem_cmd_o   = stage_data_r;
  assign bus.mem_cmd_v_o = stage_v_r;

  bp_uce_mem_arb_order_fifo #(
    .depth_p (max_outstanding_p)
  ) order_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push_c),
    .data_i    (push_src_c),
    .pop_i     (pop_c),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Route the response to the oldest outstanding requester; orphans are dropped
  always_comb begin
    bus.resp0_v_o       = 1'b0;
    bus.resp1_v_o       = 1'b0;
    bus.mem_resp_yumi_o = 1'b0;
    if (fifo_empty) begin
      bus.mem_resp_yumi_o = bus.mem_resp_v_i;
    end else if (fifo_head == e_src_dcache) begin
      bus.resp1_v_o       = bus.mem_resp_v_i;
      bus.mem_resp_yumi_o = bus.resp1_yumi_i;
    end else begin
      bus.resp0_v_o       = bus.mem_resp_v_i;
      bus.mem_resp_yumi_o = bus.resp0_yumi_i;
    end
  end

  assign pop_c       = ~fifo_empty & bus.mem_resp_yumi_o;
  assign bus.resp0_o = bus.mem_resp_i;
  assign bus.resp1_o = bus.mem_resp_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                              error_r <= 1'b0;
    else if (bus.mem_resp_v_i && fifo_empty)     error_r <= 1'b1;
  end

  assign bus.outstanding_o = fifo_count;
  assign bus.error_o       = error_r;

endmodule

// File: tb/tb_bp_uce_mem_arbiter.sv
// Self-checking bench for bp_uce_mem_arbiter: queue-based reference model plus directed literal checks.
module tb_bp_uce_mem_arbiter;

  localparam int unsigned MSG = 600;
  localparam int unsigned MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_uce_mem_arbiter_if #(.msg_width_p(MSG), .max_outstanding_p(MAX)) bus_if ();

  bp_uce_mem_arbiter #(.msg_width_p(MSG), .max_outstanding_p(MAX)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [MSG-1:0] act, input logic [MSG-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: stage contents, tracker queue, round-robin memory, error flag
  bit             m_stg_v = 1'b0;
  logic [MSG-1:0] m_stg   = '0;
  bit             m_q[$];
  int             m_last  = 1;
  bit             m_err   = 1'b0;
  int             xfer_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_stg_v = 1'b0; m_stg = '0; m_q.delete(); m_last = 1; m_err = 1'b0;
    end else begin
      bit acc, er0, er1, x0, x1, erv0, erv1, eyumi;
      int tie_winner;
      acc = (!m_stg_v || bus_if.mem_cmd_ready_i) && (m_q.size() < int'(MAX));
`ifdef BP_UCE_MEM_ARB_FIXED_PRIO_EN
      tie_winner = 0;
`else
      tie_winner = (m_last == 0) ? 1 : 0;
`endif
      er0 = acc && (!bus_if.cmd1_v_i || tie_winner == 0);
      er1 = acc && (!bus_if.cmd0_v_i || tie_winner == 1);
      x0  = bus_if.cmd0_v_i && er0;
      x1  = bus_if.cmd1_v_i && er1;
      erv0 = 1'b0; erv1 = 1'b0;
      if (m_q.size() == 0) eyumi = bus_if.mem_resp_v_i;
      else if (m_q[0]) begin erv1 = bus_if.mem_resp_v_i; eyumi = bus_if.resp1_yumi_i; end
      else             begin erv0 = bus_if.mem_resp_v_i; eyumi = bus_if.resp0_yumi_i; end

      chk("cmd0_ready", MSG'(bus_if.cmd0_ready_o), MSG'(er0));
      chk("cmd1_ready", MSG'(bus_if.cmd1_ready_o), MSG'(er1));
      chk("mem_cmd_v", MSG'(bus_if.mem_cmd_v_o), MSG'(m_stg_v));
      if (m_stg_v) chk("mem_cmd", bus_if.mem_cmd_o, m_stg);
      chk("resp0_v", MSG'(bus_if.resp0_v_o), MSG'(erv0));
      chk("resp1_v", MSG'(bus_if.resp1_v_o), MSG'(erv1));
      chk("mem_resp_yumi", MSG'(bus_if.mem_resp_yumi_o), MSG'(eyumi));
      if (bus_if.mem_resp_v_i) begin
        chk("resp0_data", bus_if.resp0_o, bus_if.mem_resp_i);
        chk("resp1_data", bus_if.resp1_o, bus_if.mem_resp_i);
      end
      chk("outstanding", MSG'(bus_if.outstanding_o), MSG'(m_q.size()));
      chk("error", MSG'(bus_if.error_o), MSG'(m_err));

      if (bus_if.mem_resp_v_i && m_q.size() == 0) m_err = 1'b1;
      if (m_q.size() != 0 && eyumi) void'(m_q.pop_front());
      if (x0 || x1) begin
        m_q.push_back(x1);
        xfer_log.push_back(x1 ? 1 : 0);
        m_stg_v = 1'b1;
        m_stg   = x1 ? bus_if.cmd1_i : bus_if.cmd0_i;
        m_last  = x1 ? 1 : 0;
      end else if (bus_if.mem_cmd_ready_i) begin
        m_stg_v = 1'b0;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  function automatic logic [MSG-1:0] tag(input int unsigned base, input int unsigned i);
    return MSG'(base + i);
  endfunction

  task automatic drain_resp(input int n, input int unsigned base);
    bus_if.mem_resp_v_i = 1'b1; bus_if.resp0_yumi_i = 1'b1; bus_if.resp1_yumi_i = 1'b1;
    for (int i = 0; i < n; i++) begin bus_if.mem_resp_i = tag(base, i); cyc(); end
    bus_if.mem_resp_v_i = 1'b0; bus_if.resp0_yumi_i = 1'b0; bus_if.resp1_yumi_i = 1'b0;
  endtask

  initial begin
    bus_if.cmd0_i = '0; bus_if.cmd0_v_i = 1'b0; bus_if.cmd1_i = '0; bus_if.cmd1_v_i = 1'b0;
    bus_if.mem_cmd_ready_i = 1'b0; bus_if.mem_resp_i = '0; bus_if.mem_resp_v_i = 1'b0;
    bus_if.resp0_yumi_i = 1'b0; bus_if.resp1_yumi_i = 1'b0;

    cyc(3);
    #1;
    chk("rst_mem_cmd_v", MSG'(bus_if.mem_cmd_v_o), '0);
    chk("rst_outstanding", MSG'(bus_if.outstanding_o), '0);
    chk("rst_error", MSG'(bus_if.error_o), '0);
    rst_n = 1'b1;
    cyc();

    // Both requesters valid from reset, memory always ready
    bus_if.mem_cmd_ready_i = 1'b1;
    bus_if.cmd0_v_i = 1'b1; bus_if.cmd1_v_i = 1'b1;
    bus_if.cmd0_i = tag(32'hA000, 0); bus_if.cmd1_i = tag(32'hB000, 0);
    #1;
    chk("first_ready0", MSG'(bus_if.cmd0_ready_o), MSG'(1));
    chk("first_ready1", MSG'(bus_if.cmd1_ready_o), MSG'(0));
    cyc();
    chk("first_issue_v", MSG'(bus_if.mem_cmd_v_o), MSG'(1));
    chk("first_issue_data", bus_if.mem_cmd_o, tag(32'hA000, 0));
    for (int i = 1; i < 4; i++) begin
      bus_if.cmd0_i = tag(32'hA000, i); bus_if.cmd1_i = tag(32'hB000, i);
      cyc();
    end
    bus_if.cmd0_v_i = 1'b0; bus_if.cmd1_v_i = 1'b0;
    #1;
    chk("rr_outstanding", MSG'(bus_if.outstanding_o), MSG'(4));
    chk("rr_log_len", MSG'(xfer_log.size()), MSG'(4));
    for (int i = 0; i < 4 && i < xfer_log.size(); i++) begin
`ifdef BP_UCE_MEM_ARB_FIXED_PRIO_EN
      chk($sformatf("grant_%0d", i), MSG'(xfer_log[i]), MSG'(0));
`else
      chk($sformatf("grant_%0d", i), MSG'(xfer_log[i]), MSG'(i % 2));
`endif
    end
    cyc();
    drain_resp(4, 32'hD000);
    #1;
    chk("rr_drained", MSG'(bus_if.outstanding_o), '0);

    // Back-pressure: stage held for 5 cycles, then drain and refill together
    xfer_log.delete();
    bus_if.mem_cmd_ready_i = 1'b0;
    bus_if.cmd0_v_i = 1'b1; bus_if.cmd0_i = tag(32'hC000, 0);
    cyc();
    bus_if.cmd1_v_i = 1'b1; bus_if.cmd1_i = tag(32'hC100, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready0", MSG'(bus_if.cmd0_ready_o), '0);
      chk("stall_ready1", MSG'(bus_if.cmd1_ready_o), '0);
      chk("stall_data", bus_if.mem_cmd_o, tag(32'hC000, 0));
      cyc();
    end
    bus_if.mem_cmd_ready_i = 1'b1;
    #1;
`ifdef BP_UCE_MEM_ARB_FIXED_PRIO_EN
    chk("release_ready0", MSG'(bus_if.cmd0_ready_o), MSG'(1));
`else
    chk("release_ready1", MSG'(bus_if.cmd1_ready_o), MSG'(1));
`endif
    cyc();
    bus_if.cmd0_v_i = 1'b0; bus_if.cmd1_v_i = 1'b0;
    cyc();
    drain_resp(2, 32'hD100);

    // Fill the tracker to its limit, then free one slot
    bus_if.cmd0_v_i = 1'b1;
    for (int i = 0; i < int'(MAX); i++) begin bus_if.cmd0_i = tag(32'hE000, i); cyc(); end
    #1;
    chk("full_outstanding", MSG'(bus_if.outstanding_o), MSG'(MAX));
    chk("full_ready0", MSG'(bus_if.cmd0_ready_o), '0);
    bus_if.mem_resp_v_i = 1'b1; bus_if.resp0_yumi_i = 1'b1; bus_if.mem_resp_i = tag(32'hD200, 0);
    #1;
    chk("full_no_bypass", MSG'(bus_if.cmd0_ready_o), '0);
    cyc();
    bus_if.mem_resp_v_i = 1'b0; bus_if.resp0_yumi_i = 1'b0;
    #1;
    chk("freed_outstanding", MSG'(bus_if.outstanding_o), MSG'(MAX - 1));
    chk("freed_ready0", MSG'(bus_if.cmd0_ready_o), MSG'(1));
    cyc();
    bus_if.cmd0_v_i = 1'b0;
    drain_resp(int'(MAX), 32'hD300);

    // Source order 1,0,0 and a stalled response consumer
    bus_if.cmd1_v_i = 1'b1; bus_if.cmd1_i = tag(32'hF100, 0);
    cyc();
    bus_if.cmd1_v_i = 1'b0; bus_if.cmd0_v_i = 1'b1; bus_if.cmd0_i = tag(32'hF000, 0);
    cyc();
    bus_if.cmd0_i = tag(32'hF000, 1);
    cyc();
    bus_if.cmd0_v_i = 1'b0;
    bus_if.mem_resp_v_i = 1'b1; bus_if.mem_resp_i = tag(32'hD400, 0);
    bus_if.resp1_yumi_i = 1'b1; bus_if.resp0_yumi_i = 1'b0;
    #1;
    chk("order_resp1_v", MSG'(bus_if.resp1_v_o), MSG'(1));
    chk("order_resp0_v", MSG'(bus_if.resp0_v_o), '0);
    chk("order_yumi", MSG'(bus_if.mem_resp_yumi_o), MSG'(1));
    cyc();
    bus_if.resp1_yumi_i = 1'b0;
    #1;
    chk("hold_resp0_v", MSG'(bus_if.resp0_v_o), MSG'(1));
    chk("hold_yumi", MSG'(bus_if.mem_resp_yumi_o), '0);
    cyc(2);
    chk("hold_outstanding", MSG'(bus_if.outstanding_o), MSG'(2));
    bus_if.resp0_yumi_i = 1'b1;
    cyc(2);
    bus_if.mem_resp_v_i = 1'b0; bus_if.resp0_yumi_i = 1'b0;
    #1;
    chk("order_drained", MSG'(bus_if.outstanding_o), '0);

    // Orphan response with nothing outstanding
    bus_if.mem_resp_v_i = 1'b1; bus_if.mem_resp_i = tag(32'hD500, 0);
    #1;
    chk("orphan_yumi", MSG'(bus_if.mem_resp_yumi_o), MSG'(1));
    chk("orphan_resp0_v", MSG'(bus_if.resp0_v_o), '0);
    chk("orphan_resp1_v", MSG'(bus_if.resp1_v_o), '0);
    cyc();
    bus_if.mem_resp_v_i = 1'b0;
    #1;
    chk("error_set", MSG'(bus_if.error_o), MSG'(1));
    cyc(3);
    chk("error_sticky", MSG'(bus_if.error_o), MSG'(1));

    // Asynchronous reset with three commands in flight
    bus_if.cmd0_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin bus_if.cmd0_i = tag(32'h9000, i); cyc(); end
    bus_if.cmd0_v_i = 1'b0; bus_if.mem_cmd_ready_i = 1'b0;
    #1;
    chk("pre_rst_outstanding", MSG'(bus_if.outstanding_o), MSG'(3));
    chk("pre_rst_mem_cmd_v", MSG'(bus_if.mem_cmd_v_o), MSG'(1));
    rst_n = 1'b0;
    #1;
    chk("async_mem_cmd_v", MSG'(bus_if.mem_cmd_v_o), '0);
    chk("async_outstanding", MSG'(bus_if.outstanding_o), '0);
    chk("async_error", MSG'(bus_if.error_o), '0);
    cyc(2);
    rst_n = 1'b1;
    bus_if.mem_cmd_ready_i = 1'b1;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_uce_mem_arbiter.md
Name: bp_uce_mem_arbiter

Overview:
- Shares one cce_mem command/response channel between two UCE requesters (port 0 = icache UCE, port 1 = dcache UCE).
- Arbitrates commands round-robin into a 1-entry registered output stage.
- Records the source of every issued command in an in-order tracking FIFO; memory responses return in command order and are routed back by FIFO head.
- Sits between the UCEs and the memory/DRAM model at the core tile edge.

Parameters:
- msg_width_p, 600, width of the packed cce_mem message (command and response).
- max_outstanding_p, 8, tracking FIFO depth and maximum in-flight commands; power of 2, at least 2.
- ptr_width_lp, clog2(max_outstanding_p), local.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- cmd0_i  in  msg_width_p  requester 0 command.
- cmd0_v_i  in  1  requester 0 command valid.
- cmd0_ready_o  out  1  ready; transfer when v&ready.
- cmd1_i, cmd1_v_i, cmd1_ready_o  as above for requester 1.
- mem_cmd_o  out  msg_width_p  arbitrated command.
- mem_cmd_v_o  out  1  valid.
- mem_cmd_ready_i  in  1  memory ready.
- mem_resp_i  in  msg_width_p  memory response.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed.
- resp0_o  out  msg_width_p  routed response, requester 0.
- resp0_v_o  out  1  valid.
- resp0_yumi_i  in  1  consumed.
- resp1_o, resp1_v_o, resp1_yumi_i  as above for requester 1.
- outstanding_o  out  ptr_width_lp+1  in-flight command count.
- error_o  out  1  sticky: response arrived with empty tracking FIFO.

Behaviour:
- Reset (async, reset_n_i=0): mem_cmd_v_o=0, output buffer empty, FIFO empty, outstanding_o=0, error_o=0, last_grant=1 (requester 0 wins first).
- Output stage:
  - Command accepted in cycle N appears on mem_cmd_v_o in N+1.
  - mem_cmd_o is held stable while mem_cmd_v_o & !mem_cmd_ready_i.
  - Stage may accept a new command in the same cycle it drains (v&ready).
- Accept condition: stage empty-or-draining AND FIFO not full.
  - FIFO full blocks acceptance even if a response is dequeued that cycle (no same-cycle bypass).
- Grant:
  - Only one requester valid: it wins.
  - Both valid: the one not equal to last_grant wins.
  - last_grant updates only on an actual transfer.
  - cmdX_ready_o = accept & grant==X; never asserted for a non-granted port.
  - cmdX_ready_o must not depend on cmdX_v_i of the same port.
- Tracking:
  - On each accept, the source id is pushed into the FIFO; the push happens at accept, not at mem issue.
  - outstanding_o = FIFO occupancy: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Response route:
  - If FIFO non-empty: respH_v_o = mem_resp_v_i for head H, the other respX_v_o=0.
  - resp0_o and resp1_o both carry mem_resp_i.
  - mem_resp_yumi_o = respH_yumi_i; FIFO pops on mem_resp_yumi_o. Zero-latency pass-through.
- mem_resp_v_i with FIFO empty: no resp valid, mem_resp_yumi_o=1 (drop), error_o set until reset.
- Pointer wrap: read/write pointers wrap modulo max_outstanding_p; full/empty use an extra wrap bit.

Optional Feature:
- Macro BP_UCE_MEM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid; last_grant is unused.
- Undefined: round-robin as above.
- All other behaviour is identical.

Decomposition:
- bp_me_pkg gets the typedef bp_uce_arb_src_e {e_src_icache=0, e_src_dcache=1}.
- Sub-module bp_uce_mem_arb_order_fifo: depth max_outstanding_p, 1-bit entries, push/pop/full/empty/count, async active-low reset.
- Grant logic and output stage are inline.

Test Plan:
- Both cmd valid from reset, ready=1 → grants 0,1,0,1 on consecutive cycles; mem_cmd_v_o one cycle after each accept. Fixed-prio build: 0,0,0,…
- mem_cmd_ready_i=0 for 5 cycles with a command in the stage → mem_cmd_o stable, both cmd ready_o=0; release → drains, next accept in the same cycle.
- Issue 8 commands with no responses (max=8) → outstanding_o=8, ready_o=0. One response yumi → count 7, accept resumes next cycle.
- Issue src order 1,0,0 → responses routed to resp1, resp0, resp0 in order. resp0_yumi_i held low → mem_resp_yumi_o=0, FIFO holds.
- mem_resp_v_i=1 after reset with nothing issued → mem_resp_yumi_o=1, error_o=1 and stays set.
- Reset asserted mid-stream with 3 outstanding → all outputs return to reset values immediately (async).
